// File: rtl/extern_req_pacer.sv
// rtl/extern_req_pacer.sv - request-pacing FIFO ahead of the single-cycle divider extern
// Optional EXTERN_REQ_PACER_STATS_EN adds drop_count and high_water outputs.
module extern_req_pacer #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16,
  parameter int ISSUE_GAP  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     req_in_valid,
  input  logic [DATA_WIDTH-1:0]    req_in,
  output logic                     req_out_valid,
  output logic [DATA_WIDTH-1:0]    req_out,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
`ifdef EXTERN_REQ_PACER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]     drop_count,
  output logic [$clog2(DEPTH):0]   high_water
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(ISSUE_GAP) + 1;

  typedef enum logic {S_READY, S_GAP} state_t;

  state_t          state, state_next;
  logic [GW-1:0]   gap_cnt, gap_next;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level_next;
  logic            issue_now, wr_en, drop;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // A full FIFO still takes a write when an entry leaves in the same cycle.
  always_comb begin
    issue_now = (state == S_READY) && (level != '0);
    wr_en     = req_in_valid && (!full || issue_now);
    drop      = req_in_valid && !wr_en;
  end

  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    case (state)
      S_READY: begin
        if (issue_now && (ISSUE_GAP > 1)) begin
          gap_next   = GW'(ISSUE_GAP - 1);
          state_next = S_GAP;
        end
      end
      S_GAP: begin
        gap_next = gap_cnt - GW'(1);
        if (gap_cnt == GW'(1)) begin
          state_next = S_READY;
        end
      end
      default: state_next = S_READY;
    endcase
  end

  always_comb begin
    level_next = level;
    case ({wr_en, issue_now})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase
  end

  // Storage is not reset; level and pointers alone define which entries are live.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_ptr] <= req_in;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= S_READY;
      gap_cnt       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      req_out_valid <= 1'b0;
      req_out       <= '0;
      overflow      <= 1'b0;
    end else begin
      state    <= state_next;
      gap_cnt  <= gap_next;
      level    <= level_next;
      overflow <= drop;
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (issue_now) begin
        rd_ptr        <= rd_ptr + AW'(1);
        req_out       <= mem[rd_ptr];
        req_out_valid <= 1'b1;
      end else begin
        req_out       <= '0;
        req_out_valid <= 1'b0;
      end
    end
  end

`ifdef EXTERN_REQ_PACER_STATS_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      drop_count <= '0;
      high_water <= '0;
    end else begin
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + CNT_WIDTH'(1);
      end
      if (level_next > high_water) begin
        high_water <= level_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_extern_req_pacer.sv
// tb/tb_extern_req_pacer.sv - directed vector bench for extern_req_pacer
// Instance a: DEPTH=16 ISSUE_GAP=2; instance b: DEPTH=4 ISSUE_GAP=4.
module tb_extern_req_pacer;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;

  logic        vin_a = 1'b0;
  logic [63:0] din_a = '0;
  logic        vout_a;
  logic [63:0] dout_a;
  logic [4:0]  level_a;
  logic        full_a, empty_a, ovf_a;

  logic        vin_b = 1'b0;
  logic [63:0] din_b = '0;
  logic        vout_b;
  logic [63:0] dout_b;
  logic [2:0]  level_b;
  logic        full_b, empty_b, ovf_b;

`ifdef EXTERN_REQ_PACER_STATS_EN
  logic [15:0] drop_a, drop_b;
  logic [4:0]  hw_a;
  logic [2:0]  hw_b;
`endif

  always #5 aclk = ~aclk;

  extern_req_pacer #(.DATA_WIDTH(64), .DEPTH(16), .ISSUE_GAP(2), .CNT_WIDTH(16)) dut_a (
    .aclk(aclk), .aresetn(aresetn), .req_in_valid(vin_a), .req_in(din_a),
    .req_out_valid(vout_a), .req_out(dout_a), .level(level_a),
    .full(full_a), .empty(empty_a), .overflow(ovf_a)
`ifdef EXTERN_REQ_PACER_STATS_EN
    , .drop_count(drop_a), .high_water(hw_a)
`endif
  );

  extern_req_pacer #(.DATA_WIDTH(64), .DEPTH(4), .ISSUE_GAP(4), .CNT_WIDTH(16)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .req_in_valid(vin_b), .req_in(din_b),
    .req_out_valid(vout_b), .req_out(dout_b), .level(level_b),
    .full(full_b), .empty(empty_b), .overflow(ovf_b)
`ifdef EXTERN_REQ_PACER_STATS_EN
    , .drop_count(drop_b), .high_water(hw_b)
`endif
  );

  typedef struct {
    logic        vin;
    logic [63:0] din;
    logic        ev;
    logic [63:0] ed;
    logic [4:0]  el;
    logic        eo;
  } vec_t;

  vec_t        vt[$];
  int          total = 0;
  int          passed = 0;
  logic [63:0] got[$];
  int          space_err;
  int          last_issue;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic vin, input logic [63:0] din, input logic ev,
                     input logic [63:0] ed, input logic [4:0] el, input logic eo);
    vec_t v;
    v.vin = vin; v.din = din; v.ev = ev; v.ed = ed; v.el = el; v.eo = eo;
    vt.push_back(v);
  endtask

  // Row i: inputs held across one rising edge, outputs expected after that edge.
  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      vin_a = vt[i].vin;
      din_a = vt[i].din;
      @(negedge aclk);
      chk($sformatf("vec%0d valid", i), 64'(vout_a), 64'(vt[i].ev));
      chk($sformatf("vec%0d data", i), dout_a, vt[i].ed);
      chk($sformatf("vec%0d level", i), 64'(level_a), 64'(vt[i].el));
      chk($sformatf("vec%0d overflow", i), 64'(ovf_a), 64'(vt[i].eo));
    end
    vin_a = 1'b0;
    din_a = '0;
  endtask

  task automatic note_issue(input logic v, input logic [63:0] d, input int cyc, input int gap);
    if (v) begin
      if (last_issue >= 0 && (cyc - last_issue) < gap) space_err++;
      last_issue = cyc;
      got.push_back(d);
    end
  endtask

  initial begin
    int n_single, n_burst, n_dead, ovf_cnt, bad;
    logic [63:0] exp_b [7];

    // single request, then 8-deep burst with ISSUE_GAP=2
    add(1, 64'h0000_0003_0000_000A, 0, 0, 1, 0);
    add(0, 0, 1, 64'h0000_0003_0000_000A, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    n_single = vt.size();
    add(1, 1, 0, 0, 1, 0);  add(1, 2, 1, 1, 1, 0);
    add(1, 3, 0, 0, 2, 0);  add(1, 4, 1, 2, 2, 0);
    add(1, 5, 0, 0, 3, 0);  add(1, 6, 1, 3, 3, 0);
    add(1, 7, 0, 0, 4, 0);  add(1, 8, 1, 4, 4, 0);
    add(0, 0, 0, 0, 4, 0);  add(0, 0, 1, 5, 3, 0);
    add(0, 0, 0, 0, 3, 0);  add(0, 0, 1, 6, 2, 0);
    add(0, 0, 0, 0, 2, 0);  add(0, 0, 1, 7, 1, 0);
    add(0, 0, 0, 0, 1, 0);  add(0, 0, 1, 8, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    n_burst = vt.size();
    add(1, 64'hDEAD, 0, 0, 1, 0);
    add(0, 0, 1, 64'hDEAD, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    n_dead = vt.size();

    #2 aresetn = 1'b0;
    #1;
    chk("rst valid", 64'(vout_a), 0);
    chk("rst data", dout_a, 0);
    chk("rst level", 64'(level_a), 0);
    chk("rst empty", 64'(empty_a), 1);
    chk("rst full", 64'(full_a), 0);
    chk("rst overflow", 64'(ovf_a), 0);
    chk("rst b empty", 64'(empty_b), 1);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);

    apply_rows(0, n_burst);

    // wrap-around: 3*DEPTH requests, one every ISSUE_GAP cycles
    got.delete(); space_err = 0; last_issue = -1;
    for (int c = 0; c < 100; c++) begin
      vin_a = (c < 96) && (c % 2 == 0);
      din_a = vin_a ? 64'(32'h100 + c / 2) : '0;
      @(negedge aclk);
      note_issue(vout_a, dout_a, c, 2);
      if (ovf_a) space_err++;
    end
    vin_a = 1'b0; din_a = '0;
    chk("wrap count", 64'(got.size()), 48);
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== 64'(32'h100 + i)) bad++;
    chk("wrap order", 64'(bad), 0);
    chk("wrap spacing/drops", 64'(space_err), 0);
    chk("wrap end empty", 64'(empty_a), 1);

    // overflow on DEPTH=4 ISSUE_GAP=4: 7,8,9 dropped; full+issue accepted at 6 and 10
    exp_b = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd10};
    got.delete(); space_err = 0; last_issue = -1; ovf_cnt = 0;
    for (int c = 1; c <= 32; c++) begin
      vin_b = (c <= 10);
      din_b = (c <= 10) ? 64'(c) : '0;
      @(negedge aclk);
      note_issue(vout_b, dout_b, c, 4);
      if (ovf_b) ovf_cnt++;
      if (c == 6) begin
        chk("full+issue level", 64'(level_b), 4);
        chk("full+issue out", dout_b, 2);
        chk("full+issue no ovf", 64'(ovf_b), 0);
      end
      if (c == 5) chk("b full", 64'(full_b), 1);
      if (c == 7) chk("ovf pulse", 64'(ovf_b), 1);
    end
    vin_b = 1'b0; din_b = '0;
    chk("ovf count", 64'(ovf_cnt), 3);
    chk("b issue count", 64'(got.size()), 7);
    bad = 0;
    for (int i = 0; i < got.size() && i < 7; i++) if (got[i] !== exp_b[i]) bad++;
    chk("b order", 64'(bad), 0);
    chk("b spacing", 64'(space_err), 0);
    chk("b end level", 64'(level_b), 0);
`ifdef EXTERN_REQ_PACER_STATS_EN
    chk("b drop_count", 64'(drop_b), 3);
    chk("b high_water", 64'(hw_b), 4);
    chk("a high_water", 64'(hw_a), 4);
`endif

    // reset mid-burst at level 5
    for (int c = 1; c <= 9; c++) begin
      vin_a = 1'b1; din_a = 64'(32'h200 + c);
      @(negedge aclk);
    end
    vin_a = 1'b0; din_a = '0;
    chk("pre-reset level", 64'(level_a), 5);
    aresetn = 1'b0;
    #1;
    chk("midrst level", 64'(level_a), 0);
    chk("midrst empty", 64'(empty_a), 1);
    chk("midrst valid", 64'(vout_a), 0);
    chk("midrst data", dout_a, 0);
    bad = 0;
    repeat (2) begin
      @(posedge aclk); #1;
      if (vout_a) bad++;
    end
    @(negedge aclk);
    aresetn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      if (vout_a || level_a != 0) bad++;
    end
    chk("no stale issue", 64'(bad), 0);
    apply_rows(n_burst, n_dead);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
